// File: rtl/idecode_pkg.sv
// Shared widths, opcodes, control-field layout and the main control decode for idecode.
package idecode_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned NumRegs      = 32;
  localparam int unsigned RegAddrWidth = 5;

  localparam int unsigned WbWidth = 2;
  localparam int unsigned MWidth  = 3;
  localparam int unsigned ExWidth = 4;

  localparam int unsigned WbRegWrite = 1;
  localparam int unsigned WbMemtoReg = 0;
  localparam int unsigned MBranch    = 2;
  localparam int unsigned MMemRead   = 1;
  localparam int unsigned MMemWrite  = 0;
  localparam int unsigned ExRegDst   = 3;
  localparam int unsigned ExAluOpMsb = 2;
  localparam int unsigned ExAluOpLsb = 1;
  localparam int unsigned ExAluSrc   = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic [WbWidth-1:0] wb;
    logic [MWidth-1:0]  m;
    logic [ExWidth-1:0] ex;
  } ctrl_t;

  // The all-zero word is a NOP even though its opcode matches R-type.
  function automatic ctrl_t decode_ctrl(input logic [DataWidth-1:0] instr);
    ctrl_t c;
    c = '0;
    if (instr != '0) begin
      case (instr[31:26])
        OP_RTYPE: begin
          c.wb[WbRegWrite]               = 1'b1;
          c.ex[ExRegDst]                 = 1'b1;
          c.ex[ExAluOpMsb:ExAluOpLsb]    = AluOpFunct;
        end
        OP_LW: begin
          c.wb[WbRegWrite]               = 1'b1;
          c.wb[WbMemtoReg]               = 1'b1;
          c.m[MMemRead]                  = 1'b1;
          c.ex[ExAluOpMsb:ExAluOpLsb]    = AluOpAdd;
          c.ex[ExAluSrc]                 = 1'b1;
        end
        OP_SW: begin
          c.m[MMemWrite]                 = 1'b1;
          c.ex[ExAluOpMsb:ExAluOpLsb]    = AluOpAdd;
          c.ex[ExAluSrc]                 = 1'b1;
        end
        OP_BEQ: begin
          c.m[MBranch]                   = 1'b1;
          c.ex[ExAluOpMsb:ExAluOpLsb]    = AluOpSub;
        end
        default: c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/idecode_if.sv
// IF/ID, write-back and ID/EX signal bundle for the decode stage.
interface idecode_if;
  import idecode_pkg::*;

  logic [DataWidth-1:0]    IF_ID_instr;
  logic [DataWidth-1:0]    IF_ID_npc;
  logic                    MEM_WB_RegWrite;
  logic [RegAddrWidth-1:0] MEM_WB_WriteReg;
  logic [DataWidth-1:0]    WB_WriteData;
  logic                    EX_MEM_PCSrc;

  logic [WbWidth-1:0]      ID_EX_wb;
  logic [MWidth-1:0]       ID_EX_m;
  logic [ExWidth-1:0]      ID_EX_ex;
  logic [DataWidth-1:0]    ID_EX_npc;
  logic [DataWidth-1:0]    ID_EX_readdat1;
  logic [DataWidth-1:0]    ID_EX_readdat2;
  logic [DataWidth-1:0]    ID_EX_sign_ext;
  logic [RegAddrWidth-1:0] ID_EX_instr_2016;
  logic [RegAddrWidth-1:0] ID_EX_instr_1511;
  logic                    ID_stall;

  modport master (
    output IF_ID_instr, IF_ID_npc, MEM_WB_RegWrite, MEM_WB_WriteReg, WB_WriteData, EX_MEM_PCSrc,
    input  ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2,
           ID_EX_sign_ext, ID_EX_instr_2016, ID_EX_instr_1511, ID_stall
  );

  modport slave (
    input  IF_ID_instr, IF_ID_npc, MEM_WB_RegWrite, MEM_WB_WriteReg, WB_WriteData, EX_MEM_PCSrc,
    output ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2,
           ID_EX_sign_ext, ID_EX_instr_2016, ID_EX_instr_1511, ID_stall
  );

endinterface

// File: rtl/idecode_reg_file.sv
// 32x32 register file with two async read ports; $0 is hard-wired to zero.
// IDECODE_WB_BYPASS_EN: a read of the register being written returns the write data.
module reg_file
  import idecode_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RegAddrWidth-1:0] raddr1_i,
  input  logic [RegAddrWidth-1:0] raddr2_i,
  output logic [DataWidth-1:0]    rdata1_o,
  output logic [DataWidth-1:0]    rdata2_o,
  input  logic                    we_i,
  input  logic [RegAddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0]    wdata_i
);

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic                 wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
`ifdef IDECODE_WB_BYPASS_EN
    if (wr_en && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
`endif
    if (raddr1_i == '0) rdata1_o = '0;
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
`ifdef IDECODE_WB_BYPASS_EN
    if (wr_en && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/idecode.sv
// Decode stage: control decode, register read, sign-extend, load-use detection, ID/EX latch.
// Honours IDECODE_WB_BYPASS_EN through the register file.
module idecode
  import idecode_pkg::*;
(
  input logic      clk,
  input logic      rst,
  idecode_if.slave bus
);

  logic [RegAddrWidth-1:0] rs, rt, rt_q, rd_q;
  logic [DataWidth-1:0]    rdata1, rdata2, sign_ext;
  logic [DataWidth-1:0]    npc_q, rdata1_q, rdata2_q, sign_ext_q;
  ctrl_t                   ctrl_d, ctrl_q;
  logic                    stall;

  assign rs       = bus.IF_ID_instr[25:21];
  assign rt       = bus.IF_ID_instr[20:16];
  assign sign_ext = {{16{bus.IF_ID_instr[15]}}, bus.IF_ID_instr[15:0]};

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .we_i     (bus.MEM_WB_RegWrite),
    .waddr_i  (bus.MEM_WB_WriteReg),
    .wdata_i  (bus.WB_WriteData)
  );

  // A load in EX whose destination feeds this instruction needs one bubble.
  always_comb begin
    stall = ctrl_q.m[MMemRead] && (rt_q != '0) && ((rt_q == rs) || (rt_q == rt));
  end

  always_comb begin
    ctrl_d = decode_ctrl(bus.IF_ID_instr);
    if (bus.EX_MEM_PCSrc || stall) ctrl_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      npc_q      <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      sign_ext_q <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      npc_q      <= bus.IF_ID_npc;
      rdata1_q   <= rdata1;
      rdata2_q   <= rdata2;
      sign_ext_q <= sign_ext;
      rt_q       <= rt;
      rd_q       <= bus.IF_ID_instr[15:11];
    end
  end

  assign bus.ID_EX_wb         = ctrl_q.wb;
  assign bus.ID_EX_m          = ctrl_q.m;
  assign bus.ID_EX_ex         = ctrl_q.ex;
  assign bus.ID_EX_npc        = npc_q;
  assign bus.ID_EX_readdat1   = rdata1_q;
  assign bus.ID_EX_readdat2   = rdata2_q;
  assign bus.ID_EX_sign_ext   = sign_ext_q;
  assign bus.ID_EX_instr_2016 = rt_q;
  assign bus.ID_EX_instr_1511 = rd_q;
  assign bus.ID_stall         = stall;

endmodule

// File: tb/tb_idecode.sv
// Self-checking bench for idecode: directed literal cases plus random traffic against a model.
module tb_idecode;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idecode_if bus ();

  idecode u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // Reference state: architectural registers and the expected ID/EX contents.
  logic [31:0] m_regs [32];
  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [3:0]  e_ex;
  logic [31:0] e_npc, e_rd1, e_rd2, e_sext;
  logic [4:0]  e_rt, e_rd;
  logic        m_stall;

  function automatic logic [8:0] model_ctrl(input logic [31:0] ins);
    if (ins == 32'h0) return 9'b0;
    case (ins[31:26])
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef IDECODE_WB_BYPASS_EN
    if (bus.MEM_WB_RegWrite && bus.MEM_WB_WriteReg == a) return bus.WB_WriteData;
`endif
    return m_regs[a];
  endfunction

  assign m_stall = e_m[1] && (e_rt != 5'd0) &&
                   ((e_rt == bus.IF_ID_instr[25:21]) || (e_rt == bus.IF_ID_instr[20:16]));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      {e_wb, e_m, e_ex} <= 9'b0;
      e_npc  <= 32'h0;
      e_rd1  <= 32'h0;
      e_rd2  <= 32'h0;
      e_sext <= 32'h0;
      e_rt   <= 5'd0;
      e_rd   <= 5'd0;
    end else begin
      {e_wb, e_m, e_ex} <= (bus.EX_MEM_PCSrc || m_stall) ? 9'b0 : model_ctrl(bus.IF_ID_instr);
      e_npc  <= bus.IF_ID_npc;
      e_rd1  <= model_read(bus.IF_ID_instr[25:21]);
      e_rd2  <= model_read(bus.IF_ID_instr[20:16]);
      e_sext <= 32'($signed(bus.IF_ID_instr[15:0]));
      e_rt   <= bus.IF_ID_instr[20:16];
      e_rd   <= bus.IF_ID_instr[15:11];
      if (bus.MEM_WB_RegWrite && bus.MEM_WB_WriteReg != 5'd0)
        m_regs[bus.MEM_WB_WriteReg] <= bus.WB_WriteData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("wb",      32'(bus.ID_EX_wb),         32'(e_wb));
      chk("m",       32'(bus.ID_EX_m),          32'(e_m));
      chk("ex",      32'(bus.ID_EX_ex),         32'(e_ex));
      chk("npc",     bus.ID_EX_npc,             e_npc);
      chk("rd1",     bus.ID_EX_readdat1,        e_rd1);
      chk("rd2",     bus.ID_EX_readdat2,        e_rd2);
      chk("sext",    bus.ID_EX_sign_ext,        e_sext);
      chk("rt",      32'(bus.ID_EX_instr_2016), 32'(e_rt));
      chk("rd",      32'(bus.ID_EX_instr_1511), 32'(e_rd));
      chk("stall",   32'(bus.ID_stall),         32'(m_stall));
    end
  end

  task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic we,
                       input logic [4:0] wreg, input logic [31:0] wdata, input logic pcsrc);
    bus.IF_ID_instr     = instr;
    bus.IF_ID_npc       = npc;
    bus.MEM_WB_RegWrite = we;
    bus.MEM_WB_WriteReg = wreg;
    bus.WB_WriteData    = wdata;
    bus.EX_MEM_PCSrc    = pcsrc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_all(input string tag);
    chk({tag, "_wb"},    32'(bus.ID_EX_wb),         32'h0);
    chk({tag, "_m"},     32'(bus.ID_EX_m),          32'h0);
    chk({tag, "_ex"},    32'(bus.ID_EX_ex),         32'h0);
    chk({tag, "_npc"},   bus.ID_EX_npc,             32'h0);
    chk({tag, "_rd1"},   bus.ID_EX_readdat1,        32'h0);
    chk({tag, "_rd2"},   bus.ID_EX_readdat2,        32'h0);
    chk({tag, "_sext"},  bus.ID_EX_sign_ext,        32'h0);
    chk({tag, "_rt"},    32'(bus.ID_EX_instr_2016), 32'h0);
    chk({tag, "_rd"},    32'(bus.ID_EX_instr_1511), 32'h0);
    chk({tag, "_stall"}, 32'(bus.ID_stall),         32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1, 2, 3: return {6'h00, rs, rt, rd, 5'h0, 6'h20};
      4, 5:    return {6'h23, rs, rt, 16'($urandom)};
      6:       return {6'h2B, rs, rt, 16'($urandom)};
      7:       return {6'h04, rs, rt, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic hold;
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #7;
    chk_zero_all("reset");
    #5;
    rst = 1'b0;
    checking = 1'b1;
    tick();

    // R-type with operands written through the WB port.
    drive(32'h0, 32'h4, 1'b1, 5'd5, 32'd7, 1'b0);
    tick();
    drive(32'h0, 32'h8, 1'b1, 5'd6, 32'd9, 1'b0);
    tick();
    drive(32'h00A62020, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("rtype_rd1", bus.ID_EX_readdat1, 32'd7);
    chk("rtype_rd2", bus.ID_EX_readdat2, 32'd9);
    chk("rtype_ex", 32'(bus.ID_EX_ex), 32'hC);
    chk("rtype_m", 32'(bus.ID_EX_m), 32'h0);
    chk("rtype_wb", 32'(bus.ID_EX_wb), 32'h2);
    chk("rtype_rd", 32'(bus.ID_EX_instr_1511), 32'd4);
    chk("rtype_npc", bus.ID_EX_npc, 32'h10);

    // Load-use: lw $2 then add reading $2.
    drive(32'h8C220004, 32'h14, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("lw_sext", bus.ID_EX_sign_ext, 32'h4);
    chk("lw_ex", 32'(bus.ID_EX_ex), 32'h1);
    chk("lw_m", 32'(bus.ID_EX_m), 32'h2);
    chk("lw_wb", 32'(bus.ID_EX_wb), 32'h3);
    drive(32'h00422020, 32'h18, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("lu_stall_on", 32'(bus.ID_stall), 32'h1);
    tick();
    chk("lu_bubble", {29'h0, bus.ID_EX_wb, bus.ID_EX_m[0]} | 32'(bus.ID_EX_ex) |
        32'(bus.ID_EX_m), 32'h0);
    chk("lu_stall_off", 32'(bus.ID_stall), 32'h0);
    tick();
    chk("lu_add_ex", 32'(bus.ID_EX_ex), 32'hC);
    chk("lu_add_wb", 32'(bus.ID_EX_wb), 32'h2);

    // Branch, flush, and flush coinciding with a stall.
    drive(32'h1000FFFF, 32'h1C, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("beq_sext", bus.ID_EX_sign_ext, 32'hFFFFFFFF);
    chk("beq_m", 32'(bus.ID_EX_m), 32'h4);
    chk("beq_ex", 32'(bus.ID_EX_ex), 32'h2);
    drive(32'h8C220004, 32'h20, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    chk("flush_ctrl", {23'h0, bus.ID_EX_wb, bus.ID_EX_m, bus.ID_EX_ex}, 32'h0);
    drive(32'h8C220004, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    drive(32'h00422020, 32'h28, 1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    chk("fs_stall_on", 32'(bus.ID_stall), 32'h1);
    tick();
    chk("fs_ctrl", {23'h0, bus.ID_EX_wb, bus.ID_EX_m, bus.ID_EX_ex}, 32'h0);

    // Writes to $0 are discarded.
    drive(32'h0, 32'h2C, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0);
    tick();
    drive(32'h00000020, 32'h30, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("r0_read", bus.ID_EX_readdat1, 32'h0);

    // Same-cycle write and read of $7.
    drive(32'h0, 32'h34, 1'b1, 5'd7, 32'h11111111, 1'b0);
    tick();
    drive(32'h00E00020, 32'h38, 1'b1, 5'd7, 32'h12345678, 1'b0);
    tick();
`ifdef IDECODE_WB_BYPASS_EN
    chk("bypass_rd1", bus.ID_EX_readdat1, 32'h12345678);
`else
    chk("bypass_rd1", bus.ID_EX_readdat1, 32'h11111111);
`endif

    // Asynchronous reset in the middle of a cycle.
    drive(32'h00A62020, 32'h3C, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_zero_all("async_rst");
    #2;
    rst = 1'b0;
    for (int r = 1; r < 32; r++) begin
      drive({6'h00, 5'(r), 5'(r), 5'd1, 11'h020}, 32'(r), 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      chk("rst_regs", bus.ID_EX_readdat1 | bus.ID_EX_readdat2, 32'h0);
    end

    // Random traffic; IF/ID holds its instruction while a stall is raised.
    for (int n = 0; n < 3000; n++) begin
      hold = m_stall;
      tick();
      bus.MEM_WB_RegWrite = ($urandom_range(0, 1) == 1);
      bus.MEM_WB_WriteReg = 5'($urandom_range(0, 7));
      bus.WB_WriteData    = $urandom;
      bus.EX_MEM_PCSrc    = ($urandom_range(0, 7) == 0);
      if (!hold) begin
        bus.IF_ID_instr = rand_instr();
        bus.IF_ID_npc   = $urandom;
      end
    end
    tick();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
